// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fetch-side instruction memory responder with programmable wait states
// Optional feature macro: IMEM_PREFETCH_EN (1-entry next-halfword prefetch buffer)
module instr_mem_responder #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          MEM_WORDS   = 2048,
  parameter logic [15:0] INIT_DATA   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [11:0] address,
  output logic        stall_memory,
  output logic [15:0] instruction,
  output logic        addr_error,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  // Program image; deliberately not reset so the boot image survives a core reset
  logic [15:0] mem [MEM_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic        stall_q, stall_d;
  logic [15:0] instruction_q, instruction_d;
  logic        addr_error_q, addr_error_d;
  logic [15:0] rd_data_q, rd_data_d;

`ifdef IMEM_PREFETCH_EN
  logic [10:0] pf_addr_q, pf_addr_d;
  logic [15:0] pf_data_q, pf_data_d;
  logic        pf_valid_q, pf_valid_d;
  logic        hit_q, hit_d;
  logic        fill_pending_q, fill_pending_d;
  logic        pf_hit;
`endif

  logic [10:0] rd_idx;
  logic        rd_in_range;
  logic [15:0] rd_word;
  logic [10:0] wr_idx;
  logic        wr_in_range;
  logic        unused_wr_lsb;

  // Halfword granularity: the write byte-lane bit carries no information
  assign unused_wr_lsb = wr_addr[0];
  assign wr_idx        = wr_addr[11:1];
  assign wr_in_range   = ({21'd0, wr_idx} < 32'(MEM_WORDS));

  // Single array read port: the in-flight entry, or the next halfword while idle for prefetch fill
  always_comb begin
    rd_idx = addr_q[11:1];
`ifdef IMEM_PREFETCH_EN
    if (state_q == S_IDLE) begin
      rd_idx = addr_q[11:1] + 11'd1;
    end
`endif
    rd_in_range = ({21'd0, rd_idx} < 32'(MEM_WORDS));
    rd_word     = rd_in_range ? mem[rd_idx] : 16'h0000;
  end

  // Image load port; accepted in any FSM state, visible to reads from the next cycle
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Next-state and next-output computation for the read FSM
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    stall_d       = stall_q;
    instruction_d = instruction_q;
    addr_error_d  = addr_error_q;
    rd_data_d     = rd_data_q;
`ifdef IMEM_PREFETCH_EN
    pf_addr_d      = pf_addr_q;
    pf_data_d      = pf_data_q;
    pf_valid_d     = pf_valid_q;
    hit_d          = hit_q;
    fill_pending_d = 1'b0;
    pf_hit         = pf_valid_q && (address[11:1] == pf_addr_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (read_enable) begin
          addr_d = address;
          cnt_d  = WAIT_LOAD;
`ifdef IMEM_PREFETCH_EN
          hit_d  = pf_hit;
          if (pf_hit) begin
            cnt_d   = 4'd0;
            state_d = S_DONE;
            stall_d = 1'b0;
          end else
`endif
          if (ZERO_WAIT) begin
            state_d = S_DONE;
            stall_d = 1'b0;
          end else begin
            state_d = S_BUSY;
            stall_d = 1'b1;
          end
        end
`ifdef IMEM_PREFETCH_EN
        else if (fill_pending_q) begin
          // Speculatively fetch the halfword following the last completed read
          pf_addr_d  = rd_idx;
          pf_data_d  = rd_word;
          pf_valid_d = 1'b1;
        end
`endif
      end

      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Last wait state: sample the array so late image writes are still seen
          rd_data_d = rd_word;
          state_d   = S_DONE;
          stall_d   = 1'b0;
        end
      end

      S_DONE: begin
`ifdef IMEM_PREFETCH_EN
        if (hit_q) begin
          instruction_d = pf_data_q;
        end else
`endif
        begin
          instruction_d = ZERO_WAIT ? rd_word : rd_data_q;
        end
        addr_error_d = addr_q[0];
        stall_d      = 1'b0;
        state_d      = S_IDLE;
`ifdef IMEM_PREFETCH_EN
        hit_d          = 1'b0;
        fill_pending_d = 1'b1;
`endif
      end

      default: begin
        state_d = S_IDLE;
        stall_d = 1'b0;
      end
    endcase

`ifdef IMEM_PREFETCH_EN
    // A load into the buffered entry makes the buffered copy stale
    if (wr_en && (wr_idx == pf_addr_d)) begin
      pf_valid_d = 1'b0;
    end
`endif
  end

  // FSM state and registered outputs; reset aborts any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      addr_q        <= 12'd0;
      stall_q       <= 1'b0;
      instruction_q <= INIT_DATA;
      addr_error_q  <= 1'b0;
      rd_data_q     <= 16'h0000;
`ifdef IMEM_PREFETCH_EN
      pf_addr_q      <= 11'd0;
      pf_data_q      <= 16'h0000;
      pf_valid_q     <= 1'b0;
      hit_q          <= 1'b0;
      fill_pending_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      stall_q       <= stall_d;
      instruction_q <= instruction_d;
      addr_error_q  <= addr_error_d;
      rd_data_q     <= rd_data_d;
`ifdef IMEM_PREFETCH_EN
      pf_addr_q      <= pf_addr_d;
      pf_data_q      <= pf_data_d;
      pf_valid_q     <= pf_valid_d;
      hit_q          <= hit_d;
      fill_pending_q <= fill_pending_d;
`endif
    end
  end

  assign stall_memory = stall_q;
  assign instruction  = instruction_q;
  assign addr_error   = addr_error_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed self-checking bench for instr_mem_responder
module tb_instr_mem_responder;

  logic        clk;
  logic        reset;
  logic        read_enable;
  logic [11:0] address;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;

  logic        stall0, stall2, stall3;
  logic [15:0] instr0, instr2, instr3;
  logic        err0, err2, err3;

  int checks;
  int failures;

  instr_mem_responder #(.WAIT_CYCLES(0), .MEM_WORDS(2048), .INIT_DATA(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .read_enable(read_enable), .address(address),
    .stall_memory(stall0), .instruction(instr0), .addr_error(err0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instr_mem_responder #(.WAIT_CYCLES(2), .MEM_WORDS(2048), .INIT_DATA(16'h0000)) dut2 (
    .clk(clk), .reset(reset), .read_enable(read_enable), .address(address),
    .stall_memory(stall2), .instruction(instr2), .addr_error(err2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instr_mem_responder #(.WAIT_CYCLES(3), .MEM_WORDS(2048), .INIT_DATA(16'h0000)) dut3 (
    .clk(clk), .reset(reset), .read_enable(read_enable), .address(address),
    .stall_memory(stall3), .instruction(instr3), .addr_error(err3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [11:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL reset_stall0 got=%0b exp=0", stall0); end
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL reset_stall2 got=%0b exp=0", stall2); end
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL reset_stall3 got=%0b exp=0", stall3); end
    checks++; if (instr2 !== 16'h0000) begin failures++; $display("FAIL reset_instr2 got=%h exp=0000", instr2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err2 got=%0b exp=0", err2); end
    reset = 1'b0;
  endtask

  task automatic test_wait2();
    pulse_reset();
    write_word(12'h010, 16'hA5A5);
    read_enable = 1'b1;
    address     = 12'h010;
    tick();
    read_enable = 1'b0;
    checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL wait2_stall_c1 got=%0b exp=1", stall2); end
    tick();
    checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL wait2_stall_c2 got=%0b exp=1", stall2); end
    tick();
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL wait2_stall_c3 got=%0b exp=0", stall2); end
    checks++; if (instr2 !== 16'h0000) begin failures++; $display("FAIL wait2_instr_early got=%h exp=0000", instr2); end
    tick();
    checks++; if (instr2 !== 16'hA5A5) begin failures++; $display("FAIL wait2_instr got=%h exp=a5a5", instr2); end
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL wait2_stall_done got=%0b exp=0", stall2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL wait2_err got=%0b exp=0", err2); end
  endtask

  task automatic test_zero_wait_back_to_back();
    pulse_reset();
    write_word(12'h000, 16'h1111);
    write_word(12'h002, 16'h2222);
    read_enable = 1'b1;
    address     = 12'h000;
    tick();
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL zw_stall_a got=%0b exp=0", stall0); end
    address = 12'h002;
    tick();
    checks++; if (instr0 !== 16'h1111) begin failures++; $display("FAIL zw_instr_a got=%h exp=1111", instr0); end
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL zw_stall_a2 got=%0b exp=0", stall0); end
    tick();
    read_enable = 1'b0;
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL zw_stall_b got=%0b exp=0", stall0); end
    tick();
    checks++; if (instr0 !== 16'h2222) begin failures++; $display("FAIL zw_instr_b got=%h exp=2222", instr0); end
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL zw_stall_b2 got=%0b exp=0", stall0); end
  endtask

  task automatic test_misaligned();
    pulse_reset();
    write_word(12'h012, 16'h5A5A);
    read_enable = 1'b1;
    address     = 12'h011;
    tick();
    read_enable = 1'b0;
    tick();
    checks++; if (instr0 !== 16'hA5A5) begin failures++; $display("FAIL mis_instr got=%h exp=a5a5", instr0); end
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL mis_err got=%0b exp=1", err0); end
    tick();
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL mis_err_held got=%0b exp=1", err0); end
    read_enable = 1'b1;
    address     = 12'h012;
    tick();
    read_enable = 1'b0;
    tick();
    checks++; if (instr0 !== 16'h5A5A) begin failures++; $display("FAIL mis_next_instr got=%h exp=5a5a", instr0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL mis_next_err got=%0b exp=0", err0); end
  endtask

  task automatic test_reset_mid_read();
    pulse_reset();
    read_enable = 1'b1;
    address     = 12'h010;
    tick();
    read_enable = 1'b0;
    checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=1", stall3); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%0b exp=0", stall3); end
    checks++; if (instr3 !== 16'h0000) begin failures++; $display("FAIL rst_mid_instr got=%h exp=0000", instr3); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (instr3 !== 16'h0000) begin failures++; $display("FAIL rst_mid_no_data got=%h exp=0000", instr3); end
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%0b exp=0", stall3); end
    read_enable = 1'b1;
    address     = 12'h012;
    tick();
    read_enable = 1'b0;
    checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL rst_after_stall got=%0b exp=1", stall3); end
    tick();
    tick();
    tick();
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL rst_after_stall_end got=%0b exp=0", stall3); end
    tick();
    checks++; if (instr3 !== 16'h5A5A) begin failures++; $display("FAIL rst_after_instr got=%h exp=5a5a", instr3); end
  endtask

  task automatic test_busy_ignore();
    pulse_reset();
    write_word(12'h040, 16'h4040);
    write_word(12'h014, 16'h1414);
    read_enable = 1'b1;
    address     = 12'h014;
    tick();
    address = 12'h040;
    tick();
    read_enable = 1'b0;
    tick();
    tick();
    checks++; if (instr2 !== 16'h1414) begin failures++; $display("FAIL busy_ign_instr got=%h exp=1414", instr2); end
    tick();
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL busy_ign_no_restart got=%0b exp=0", stall2); end
    tick();
    checks++; if (instr2 !== 16'h1414) begin failures++; $display("FAIL busy_ign_held got=%h exp=1414", instr2); end
  endtask

`ifdef IMEM_PREFETCH_EN
  task automatic test_prefetch();
    pulse_reset();
    write_word(12'h020, 16'h2020);
    write_word(12'h022, 16'hC0DE);
    read_enable = 1'b1;
    address     = 12'h020;
    tick();
    read_enable = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (instr2 !== 16'h2020) begin failures++; $display("FAIL pf_first got=%h exp=2020", instr2); end
    tick();
    read_enable = 1'b1;
    address     = 12'h022;
    tick();
    read_enable = 1'b0;
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL pf_hit_stall got=%0b exp=0", stall2); end
    tick();
    checks++; if (instr2 !== 16'hC0DE) begin failures++; $display("FAIL pf_hit_instr got=%h exp=c0de", instr2); end
    pulse_reset();
    read_enable = 1'b1;
    address     = 12'h020;
    tick();
    read_enable = 1'b0;
    tick();
    tick();
    tick();
    tick();
    write_word(12'h022, 16'hBEEF);
    read_enable = 1'b1;
    address     = 12'h022;
    tick();
    read_enable = 1'b0;
    checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL pf_inv_stall got=%0b exp=1", stall2); end
    tick();
    tick();
    tick();
    checks++; if (instr2 !== 16'hBEEF) begin failures++; $display("FAIL pf_inv_instr got=%h exp=beef", instr2); end
  endtask
`endif

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    read_enable = 1'b0;
    address     = 12'h000;
    wr_en       = 1'b0;
    wr_addr     = 12'h000;
    wr_data     = 16'h0000;
    test_reset();
    test_wait2();
    test_zero_wait_back_to_back();
    test_misaligned();
    test_reset_mid_read();
    test_busy_ignore();
`ifdef IMEM_PREFETCH_EN
    test_prefetch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
